// File: rtl/wide_add_seq_pkg.sv
// Shared constants and FSM encoding for the time-shared wide adder.
package wide_add_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/wide_add_seq_cla16.sv
// 16-bit adder: 4-bit groups with group generate/propagate lookahead between groups.
module cla16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;
    logic [16:0] w_c;

    always_comb begin
        w_g  = A & B;
        w_p  = A ^ B;
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        w_c  = '0;
        for (int k = 0; k < 4; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end
        w_gc[0] = Cin;
        for (int k = 0; k < 4; k++) begin
            w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
        end
        // Group carries come from lookahead; only bits inside a group ripple.
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 0) begin
                w_c[i] = w_gc[i/4];
            end else begin
                w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
            end
        end
        w_c[16] = w_gc[4];
        S       = w_p ^ w_c[15:0];
        Cout    = w_c[16];
    end

endmodule

// File: rtl/wide_add_seq.sv
// WORDS*16-bit add/subtract sequenced LS slice first through one cla16.
// Handshake: start is taken only on a cycle with ready=1 (IDLE); otherwise it is dropped.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = SLICE_W * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic         Ofl,
    output state_t       dbg_state
);

    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic [W-1:0]       r_s;
    logic               r_cout;
    logic               r_ofl;

    logic [IDX_W+3:0]   w_base;
    logic [15:0]        w_sum;
    logic               w_cout;

    assign w_base = {r_idx, 4'b0000};

    cla16 u_cla16 (
        .A    (r_op_a[w_base +: SLICE_W]),
        .B    (r_op_b[w_base +: SLICE_W]),
        .Cin  (r_carry),
        .S    (w_sum),
        .Cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ofl   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op_a  <= A;
                        r_op_b  <= sub ? ~B : B;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_s     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s[w_base +: SLICE_W] <= w_sum;
                    r_carry                <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        // Effective B MSB makes this valid for both add and subtract.
                        r_cout  <= w_cout;
                        r_ofl   <= (r_op_a[W-1] == r_op_b[W-1]) && (w_sum[15] != r_op_a[W-1]);
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign S         = r_s;
    assign Cout      = r_cout;
    assign Ofl       = r_ofl;
    assign dbg_state = r_state;

endmodule
